// File: rtl/pipelined_sequential_subtractor.sv
// rtl/pipelined_sequential_subtractor.sv - pipelined a - b - bin, one W-bit chunk per stage, ready/valid stream
// Optional signed-overflow output and its sign-bit pipeline are enabled by defining SUB_OVERFLOW_EN.
module pipelined_sequential_subtractor #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  input  logic         valid_in,
  output logic         in_ready,
  output logic [N-1:0] s,
  output logic         bout,
  output logic         valid_out,
  input  logic         out_ready
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);
  localparam int W = N / STAGES;

  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] b_q   [STAGES];
  logic [N-1:0] res_q [STAGES];
  logic         brw_q [STAGES];
  logic         vld_q [STAGES];

  logic [N-1:0] a_in   [STAGES];
  logic [N-1:0] b_in   [STAGES];
  logic [N-1:0] res_in [STAGES];
  logic [N-1:0] res_out[STAGES];
  logic         brw_in [STAGES];
  logic         vld_in [STAGES];
  logic [W:0]   sum    [STAGES];

  logic en;
  logic unused_bits;

  assign valid_out = vld_q[STAGES-1];
  assign en        = ~valid_out | out_ready;
  assign in_ready  = en;
  assign s         = res_q[STAGES-1];
  assign bout      = brw_q[STAGES-1];

`ifdef SUB_OVERFLOW_EN
  logic [N-1:0] b_plus;
  logic         bp_q  [STAGES];
  logic         bp_in [STAGES];

  assign b_plus = b + {{(N-1){1'b0}}, bin};
  assign ovf    = (a_q[STAGES-1][N-1] != bp_q[STAGES-1]) & (res_q[STAGES-1][N-1] != a_q[STAGES-1][N-1]);
  assign unused_bits = ^{a_q[STAGES-1][N-2:0], b_q[STAGES-1], b_plus[N-2:0]};

  always_comb begin
    bp_in[0] = b_plus[N-1];
    for (int k = 1; k < STAGES; k++) bp_in[k] = bp_q[k-1];
  end
`else
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1]};
`endif

  // Chunk k subtracts as a + ~b + ~borrow; the chunk borrow is the inverted carry.
  always_comb begin
    a_in[0]   = a;
    b_in[0]   = b;
    res_in[0] = '0;
    brw_in[0] = bin;
    vld_in[0] = valid_in;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      res_in[k] = res_q[k-1];
      brw_in[k] = brw_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, a_in[k][k*W +: W]} + {1'b0, ~b_in[k][k*W +: W]} + {{W{1'b0}}, ~brw_in[k]};
      res_out[k] = res_in[k];
      res_out[k][k*W +: W] = sum[k][W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        brw_q[k] <= 1'b0;
`ifdef SUB_OVERFLOW_EN
        bp_q[k]  <= 1'b0;
`endif
      end
    end else if (en) begin
      // Bubbles advance as invalid beats but leave the data registers untouched.
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_in[k];
        if (vld_in[k]) begin
          a_q[k]   <= a_in[k];
          b_q[k]   <= b_in[k];
          res_q[k] <= res_out[k];
          brw_q[k] <= ~sum[k][W];
`ifdef SUB_OVERFLOW_EN
          bp_q[k]  <= bp_in[k];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_sequential_subtractor.sv
// tb/tb_pipelined_sequential_subtractor.sv - directed self-checking bench for pipelined_sequential_subtractor
module tb_pipelined_sequential_subtractor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, s;
  logic        bin, valid_in, in_ready, bout, valid_out, out_ready;
`ifdef SUB_OVERFLOW_EN
  logic        ovf;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [32:0] q[$];
  int          got, gaps, idx;
  logic        started;
  logic [31:0] sa, sb;

  pipelined_sequential_subtractor #(.N(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .s         (s),
    .bout      (bout),
    .valid_out (valid_out),
    .out_ready (out_ready)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tbin, input logic [31:0] es, input logic eb);
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; valid_in = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    check({tag, "_lat1"}, 64'(valid_out), 64'd0);
    repeat (2) @(negedge clk);
    check({tag, "_lat3"}, 64'(valid_out), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(valid_out), 64'd1);
    check({tag, "_s"}, 64'(s), 64'(es));
    check({tag, "_bout"}, 64'(bout), 64'(eb));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(valid_out), 64'd0);
    check({tag, "_hold"}, 64'(s), 64'(es));
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; bin = 1'b0; valid_in = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_in_reset", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_s", 64'(s), 64'd0);
    check("reset_bout", 64'(bout), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef SUB_OVERFLOW_EN
    check("reset_ovf", 64'(ovf), 64'd0);
`endif

    run_single("basic", 32'd283, 32'd50, 1'b0, 32'd233, 1'b0);
`ifdef SUB_OVERFLOW_EN
    check("basic_ovf", 64'(ovf), 64'd0);
`endif
    run_single("ripple0", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_single("ripple1", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_single("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    run_single("binonly", 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run_single("chunkb", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0);
`ifdef SUB_OVERFLOW_EN
    run_single("ovf", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0);
    check("ovf_flag", 64'(ovf), 64'd1);
`endif

    // Streaming: 200 back-to-back beats against a whole-word reference.
    q.delete(); got = 0; gaps = 0; started = 1'b0;
    fork
      begin
        sa = 32'd283; sb = 32'd50;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          a = sa; b = sb; bin = 1'b0; valid_in = 1'b1;
          q.push_back({1'b0, sa} - {1'b0, sb});
          sa += 32'd1318402; sb += 32'd182553;
        end
        @(negedge clk);
        valid_in = 1'b0;
      end
      begin
        for (int c = 0; c < 260 && got < 200; c++) begin
          @(negedge clk);
          if (valid_out) begin
            if (q.size() == 0) check("stream_extra", 64'(valid_out), 64'd0);
            else check("stream", 64'({bout, s}), 64'(q.pop_front()));
            got++; started = 1'b1;
          end else if (started) gaps++;
        end
      end
    join
    check("stream_count", 64'(got), 64'd200);
    check("stream_gaps", 64'(gaps), 64'd0);

    // Backpressure: stall the consumer for 3 cycles with the pipeline full.
    repeat (2) @(negedge clk);
    q.delete(); got = 0; idx = 0;
    for (int c = 0; c < 60 && got < 12; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c <= 8);
      #1;
      if (valid_out) begin
        if (q.size() == 0) check("bp_extra", 64'(valid_out), 64'd0);
        else if (out_ready) begin
          check("bp_data", 64'({bout, s}), 64'(q.pop_front()));
          got++;
        end else begin
          check("bp_frozen", 64'({bout, s}), 64'(q[0]));
          check("bp_in_ready", 64'(in_ready), 64'd0);
        end
      end
      if (idx < 12) begin
        a = 32'(idx) * 32'd1000003 + 32'd7;
        b = 32'(idx) * 32'd2000029;
        bin = idx[0];
        valid_in = 1'b1;
        if (in_ready) begin
          q.push_back({1'b0, a} - {1'b0, b} - 33'(bin));
          idx++;
        end
      end else valid_in = 1'b0;
    end
    out_ready = 1'b1;
    valid_in = 1'b0;
    check("bp_count", 64'(got), 64'd12);

    // Reset with 4 beats in flight; the beat offered during reset is dropped.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 32'hA0 + 32'(i); b = 32'd1; bin = 1'b0; valid_in = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; a = 32'd55; b = 32'd5;
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_bout", 64'(bout), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_flush", 64'(valid_out), 64'd0);
    end
    run_single("post_rst", 32'd1000, 32'd1, 1'b1, 32'd998, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
